// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: a fetch port and a load/store port share one
// request/grant/rvalid memory interface, with starvation protection and timeout abort.
module mem_arbiter #(
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wmask,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        err
);

  localparam int unsigned TW = $clog2(TIMEOUT + 2);
  localparam int unsigned SW = $clog2(STARVE_MAX + 2);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;  // 1 = data port owns the transaction
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wmask_q, wmask_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic          mem_req_q, mem_req_d;
  logic          if_valid_q, if_valid_d;
  logic          d_valid_q, d_valid_d;
  logic          starved;
  logic          data_win;
  logic          expired;

  assign starved  = (starve_q == SW'(STARVE_MAX));
  assign data_win = d_req && !(if_req && starved);
  assign expired  = (tmo_q == TW'(TIMEOUT - 1));

  // Next-state, request capture, counters and registered outputs
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    rdata_d    = rdata_q;
    starve_d   = starve_q;
    tmo_d      = tmo_q;
    err_d      = err_q;
    mem_req_d  = 1'b0;
    if_valid_d = 1'b0;
    d_valid_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (d_req || if_req) begin
          owner_d = data_win;
          rdata_d = 32'h0;
          tmo_d   = '0;
          state_d = S_REQ;
          if (data_win) begin
            we_d    = d_we;
            addr_d  = d_addr;
            wdata_d = d_wdata;
            wmask_d = d_wmask;
            if (if_req && !starved) starve_d = starve_q + SW'(1);
          end else begin
            we_d     = 1'b0;
            addr_d   = if_addr;
            wdata_d  = 32'h0;
            wmask_d  = 4'h0;
            starve_d = '0;
          end
        end
      end
      S_REQ: begin
        tmo_d = tmo_q + TW'(1);
        if (expired) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (mem_gnt) begin
          if (we_q) begin
            state_d = S_DONE;
          end else if (mem_rvalid) begin
            rdata_d = mem_rdata;
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        tmo_d = tmo_q + TW'(1);
        if (expired) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (mem_rvalid) begin
          rdata_d = mem_rdata;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    mem_req_d  = (state_d == S_REQ);
    if_valid_d = (state_d == S_DONE) && !owner_d;
    d_valid_d  = (state_d == S_DONE) && owner_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      wmask_q    <= 4'h0;
      rdata_q    <= 32'h0;
      starve_q   <= '0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
      mem_req_q  <= 1'b0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      rdata_q    <= rdata_d;
      starve_q   <= starve_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      mem_req_q  <= mem_req_d;
      if_valid_q <= if_valid_d;
      d_valid_q  <= d_valid_d;
    end
  end

  // One shared data register; the non-owner sees zero
  assign if_rdata  = if_valid_q ? rdata_q : 32'h0;
  assign d_rdata   = d_valid_q ? rdata_q : 32'h0;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;
  assign err       = err_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles in REQ or WAIT before abort.
REQ-002 Parameter STARVE_MAX, default 4: maximum consecutive data grants while fetch waits.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 if_req  input  1  fetch request; held with if_addr stable until if_valid.
REQ-006 if_addr  input  32  fetch word address.
REQ-007 if_valid  output  1  one-cycle fetch completion pulse.
REQ-008 if_rdata  output  32  fetched instruction, valid while if_valid=1.
REQ-009 d_req  input  1  load/store request; held with d_* fields stable until d_valid.
REQ-010 d_we  input  1  1 = store, 0 = load.
REQ-011 d_addr  input  32  data address.
REQ-012 d_wdata  input  32  store data, already forwarded and aligned.
REQ-013 d_wmask  input  4  store byte enables.
REQ-014 d_valid  output  1  one-cycle data completion pulse.
REQ-015 d_rdata  output  32  load data, valid while d_valid=1.
REQ-016 mem_req  output  1  memory request.
REQ-017 mem_we, mem_addr[32], mem_wdata[32], mem_wmask[4]  output  request fields.
REQ-018 mem_gnt  input  1  memory accepted the request this cycle.
REQ-019 mem_rvalid  input  1  read data returned this cycle.
REQ-020 mem_rdata  input  32  read data.
REQ-021 err  output  1  sticky timeout flag.

Function
REQ-022 The FSM SHALL have states IDLE, REQ, WAIT and DONE.
REQ-023 IDLE: on d_req or if_req, the winner's fields SHALL be latched into an internal request register and the FSM SHALL go to REQ; otherwise it SHALL stay in IDLE.
REQ-024 Arbitration: data wins when both are requesting, unless the starvation counter equals STARVE_MAX, in which case fetch wins.
REQ-025 Starvation counter: increments on each data grant made while if_req=1, saturates at STARVE_MAX, and clears on any fetch grant.
REQ-026 REQ: mem_req=1 and mem_* SHALL be driven from the latched register, stable until mem_gnt.
- Store: mem_gnt moves the FSM to DONE.
- Fetch or load: mem_gnt moves the FSM to WAIT.
- Fetch: mem_we=0 and mem_wmask=4'h0.
REQ-027 WAIT: mem_req=0; mem_rvalid SHALL capture mem_rdata into the output data register and move the FSM to DONE.
REQ-028 If mem_gnt and mem_rvalid are both 1 in the same REQ cycle of a read, the FSM SHALL capture the data and go directly to DONE.
REQ-029 DONE (exactly one cycle):
- The owner's valid output is 1 and the other valid output is 0.
- The rdata output holds the captured value; for a store it is 32'h0.
- The FSM returns to IDLE.
- No request is sampled in DONE.
REQ-030 Latency: the minimum read is 4 cycles from acceptance (IDLE→REQ→WAIT→DONE) with the same-cycle gnt and rvalid case at 3; a store with immediate gnt is 3 cycles.
REQ-031 A timeout counter SHALL clear on entering REQ and increment in REQ and WAIT. On reaching TIMEOUT:
- The FSM goes to DONE with rdata=32'h0.
- err is set.
- mem_req drops.
REQ-032 err SHALL remain 1 until reset.
REQ-033 mem_rvalid outside WAIT, and outside the REQ case of REQ-028, SHALL be ignored.
REQ-034 if_rdata and d_rdata SHALL share one registered data value, gated by ownership; the non-owner output reads 32'h0.

Reset
REQ-035 While rst=1, the following SHALL be forced asynchronously:
- FSM = IDLE.
- mem_req, if_valid, d_valid and err = 0.
- All data and address registers, the starvation counter and the timeout counter = 0.
REQ-036 A reset during REQ or WAIT SHALL abandon the transaction with no valid pulse; mem_req SHALL fall in the same cycle rst rises.
REQ-037 On the first rising edge after rst falls, the block SHALL sample requests in IDLE.

Verification
REQ-038 Load d_addr=32'h100, mem_gnt immediate, mem_rvalid one cycle later with 32'hDEADBEEF → d_valid for one cycle with d_rdata=32'hDEADBEEF; if_valid stays 0.
REQ-039 Store d_wdata=32'h12345678 with d_wmask=4'b0011 and mem_gnt delayed 3 cycles → mem_* fields stable for all 4 REQ cycles; d_valid pulses once, in the cycle after gnt.
REQ-040 if_req and d_req held continuously with STARVE_MAX=4 → grant order D,D,D,D,I,D,D,D,D,I…
REQ-041 mem_gnt never asserted with TIMEOUT=255 → after 255 cycles in REQ: DONE, valid=1 with rdata=0, err=1 and held until rst.
REQ-042 rst asserted mid-WAIT, then mem_rvalid asserted → no valid pulse; the FSM stays in IDLE; the next request proceeds normally.
REQ-043 mem_gnt and mem_rvalid high in the same REQ cycle of a fetch with 32'h00000013 → if_valid next cycle with if_rdata=32'h00000013.
